uart_msg_tx: RTL

//  Parametrised UART transmitter for the BASYS3 board-to-board link.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/uart_msg_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the board-to-board link (transmitter and receiver).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam int UART_DATA_BITS = 8;

   function automatic int uart_divisor(input int clock, input int baud);
      return clock / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: restart holds it at zero, bit_end_out marks the last cycle of a bit.
module uart_baud_cnt #(
   parameter int DIVISOR = 16
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic restart_in,
   output logic bit_end_out
);

   localparam int CNT_W = $clog2(DIVISOR);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: restart or wrap at the end of each bit
   always_comb begin
      cnt_d = cnt_q;
      if (restart_in) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end
   end

   // count register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_out = (cnt_q == LAST);

endmodule

// File: rtl/uart_msg_tx.sv
// Multi-byte UART transmitter: WIDTH/8 back-to-back frames, byte 0 first, LSB first.
// Optional parity bit per byte when UART_TX_PARITY_EN is defined.
module uart_msg_tx
   import uart_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CLOCK      = 65000000,
   parameter int BAUD       = 9600,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready_out,
   output logic             tx_out,
   output logic             busy_out,
   output logic             done_out
);

   localparam int DIVISOR = uart_divisor(CLOCK, BAUD);
   localparam int NBYTES  = WIDTH / UART_DATA_BITS;
   localparam int BYTE_W  = $clog2(NBYTES) + 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("uart_msg_tx: WIDTH must be a multiple of 8 and >= 8");
   end
   if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_msg_tx: CLOCK/BAUD must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_msg_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_msg_tx: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_TX_PARITY_EN
   localparam logic ODD_BIT = (PARITY_ODD != 0);
`endif

   uart_tx_state_t    state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [2:0]        bit_q, bit_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              stop_q, stop_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              bit_end_s;
   logic [2:0]        nxt_bit_s;
   logic [7:0]        cur_byte_s;

   assign nxt_bit_s  = bit_q + 3'd1;
   assign cur_byte_s = shift_q[7:0];

   uart_baud_cnt #(.DIVISOR(DIVISOR)) u_baud (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .restart_in  (state_q == IDLE),
      .bit_end_out (bit_end_s)
   );

   // frame sequencing; all outputs are computed one cycle ahead and registered
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      stop_d  = stop_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (valid_in && ready_q) begin
               state_d = START;
               shift_d = data_in;
               tx_d    = 1'b0;
               bit_d   = 3'd0;
               byte_d  = '0;
               stop_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_d = DATA;
               tx_d    = cur_byte_s[0];
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_end_s && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
               tx_d    = (^cur_byte_s) ^ ODD_BIT;
`else
               state_d = STOP;
               tx_d    = 1'b1;
               stop_d  = 1'b0;
`endif
            end else if (bit_end_s) begin
               bit_d = nxt_bit_s;
               tx_d  = cur_byte_s[nxt_bit_s];
            end else begin
               state_d = DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end_s) begin
               state_d = STOP;
               tx_d    = 1'b1;
               stop_d  = 1'b0;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP: begin
            // next byte follows immediately, with no idle gap
            if (bit_end_s && stop_q == LAST_STOP && byte_q == LAST_BYTE) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               done_d  = 1'b1;
            end else if (bit_end_s && stop_q == LAST_STOP) begin
               state_d = START;
               tx_d    = 1'b0;
               bit_d   = 3'd0;
               byte_d  = byte_q + BYTE_W'(1'b1);
               shift_d = shift_q >> UART_DATA_BITS;
            end else if (bit_end_s) begin
               stop_d = 1'b1;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= 3'd0;
         byte_q  <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_out    = tx_q;
   assign done_out  = done_q;
   assign ready_out = ready_q;
   assign busy_out  = busy_q;

endmodule
